// File: rtl/rx_fsm_if.sv
// Receiver-side serial handshake bundle for rx_fsm.
// master = receiver, slave = line driver / frame consumer.
interface rx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx;
  logic                 RTS;
  logic [DATA_BITS-1:0] Rx_Data_Out;
  logic                 Rx_Valid;
  logic                 Rx_Ack;
  logic                 Parity_Err;
  logic                 Frame_Err;

  modport master (
    input  Rx,
    input  Rx_Ack,
    output RTS,
    output Rx_Data_Out,
    output Rx_Valid,
    output Parity_Err,
    output Frame_Err
  );

  modport slave (
    output Rx,
    output Rx_Ack,
    input  RTS,
    input  Rx_Data_Out,
    input  Rx_Valid,
    input  Parity_Err,
    input  Frame_Err
  );
endinterface

// File: rtl/rx_fsm.sv
// Bit-per-clock serial frame receiver: start, MSB-first data, parity, stops.
// Define RX_PARITY_CHECK_EN to enable even-parity error reporting.
module rx_fsm #(
  parameter int STOP_BITS = 2,
  parameter int DATA_BITS = 8
) (
  input  logic      Clk,
  input  logic      Rst,
  rx_fsm_if.master  bus
);

  localparam int MAXC = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    FULL
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 p_err;
  logic                 f_err;
  logic                 rts;
  logic                 valid;
  logic [DATA_BITS-1:0] data_out;
  logic                 pe_out;
  logic                 fe_out;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      p_err    <= 1'b0;
      f_err    <= 1'b0;
      rts      <= 1'b1;
      valid    <= 1'b0;
      data_out <= '0;
      pe_out   <= 1'b0;
      fe_out   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.Rx) begin
            state <= DATA;
            cnt   <= CW'(DATA_BITS - 1);
            f_err <= 1'b0;
            rts   <= 1'b0;
          end
        end
        DATA: begin
          sh <= DATA_BITS'({sh, bus.Rx});
          if (cnt == '0) begin
            state <= PARITY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PARITY: begin
`ifdef RX_PARITY_CHECK_EN
          p_err <= (^sh) ^ bus.Rx;
`else
          p_err <= 1'b0;
`endif
          state <= STOP;
          cnt   <= CW'(STOP_BITS - 1);
        end
        STOP: begin
          // Outputs load only here so a held frame survives the next one.
          if (cnt == '0) begin
            state    <= FULL;
            valid    <= 1'b1;
            data_out <= sh;
            pe_out   <= p_err;
            fe_out   <= f_err | ~bus.Rx;
          end else begin
            cnt   <= cnt - 1'b1;
            f_err <= f_err | ~bus.Rx;
          end
        end
        FULL: begin
          if (bus.Rx_Ack) begin
            state <= IDLE;
            valid <= 1'b0;
            rts   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rts   <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RTS         = rts;
  assign bus.Rx_Valid    = valid;
  assign bus.Rx_Data_Out = data_out;
  assign bus.Parity_Err  = pe_out;
  assign bus.Frame_Err   = fe_out;

endmodule

// File: doc/rx_fsm.md
RX_FSM -- requirements
Module: rx_fsm

Interface
REQ-001 SHALL have parameter STOP_BITS, default 2, number of stop bits per frame (>=1).
REQ-002 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (>=1).
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous active-high reset, sampled on rising edge of Clk.
REQ-005 SHALL have port Rx  input  1  serial line, idle-high, synchronous to Clk.
REQ-006 SHALL have port RTS  output  1  high when a new frame may be sent (drives remote transmitter CTS).
REQ-007 SHALL have port Rx_Data_Out  output  DATA_BITS  last received data word.
REQ-008 SHALL have port Rx_Valid  output  1  Rx_Data_Out and error flags hold a completed frame.
REQ-009 SHALL have port Rx_Ack  input  1  consumer accepts the held frame.
REQ-010 SHALL have port Parity_Err  output  1  held frame failed even-parity check.
REQ-011 SHALL have port Frame_Err  output  1  at least one stop bit of held frame sampled low.

Function
REQ-012 SHALL receive frames of 1+DATA_BITS+1+STOP_BITS bits, one bit per Clk cycle: start (0), data MSB first, parity, stop bits (1).
REQ-013 SHALL implement states IDLE, DATA, PARITY, STOP, FULL.
REQ-014 IDLE: RTS=1; Rx=0 sampled -> DATA with bit counter = DATA_BITS-1; else stay.
REQ-015 DATA: shift Rx into data register MSB first; counter decrements each cycle; counter 0 -> PARITY.
REQ-016 PARITY: sample parity bit; compute error as XOR of received data bits XOR parity bit (even parity); -> STOP with stop counter = STOP_BITS-1.
REQ-017 STOP: any stop bit sampled 0 sets frame error; counter 0 -> FULL; else decrement.
REQ-018 FULL: Rx_Valid=1, Rx_Data_Out/Parity_Err/Frame_Err stable; Rx_Ack=1 -> IDLE; else stay.
REQ-019 Rx_Valid SHALL rise the cycle after the last stop bit is sampled (latency 1 cycle past frame end).
REQ-020 RTS SHALL be 1 only in IDLE; 0 in DATA, PARITY, STOP, FULL.
REQ-021 Rx SHALL be ignored in FULL; a start bit arriving while Rx_Valid=1 is not detected.
REQ-022 Rx_Ack while Rx_Valid=0 SHALL have no effect.
REQ-023 Frames with errors SHALL still be delivered (Rx_Valid=1) with the flags set.
REQ-024 Rx_Data_Out and flags SHALL retain their values after Rx_Ack until the next frame completes.
REQ-025 Rx held 0 continuously SHALL yield frames with data 0 and Frame_Err=1, each requiring Rx_Ack.

Reset
REQ-026 Rst=1 SHALL, on the next rising edge, force IDLE regardless of state, including mid-frame.
REQ-027 Reset values: RTS=1, Rx_Valid=0, Rx_Data_Out=0, Parity_Err=0, Frame_Err=0, counters 0.
REQ-028 Rst SHALL take priority over Rx and Rx_Ack in the same cycle; a partial frame is discarded.

Configuration
REQ-029 Macro RX_PARITY_CHECK_EN defined: Parity_Err computed per REQ-016.
REQ-030 Macro RX_PARITY_CHECK_EN undefined: parity bit still consumed (frame length unchanged), Parity_Err constant 0.

Verification (DATA_BITS=8, STOP_BITS=2, cycle 0 = start bit sampled)
REQ-031 Rx = 0,1,0,1,0,0,1,0,1,0,1,1 -> Rx_Valid=1 from cycle 12, Rx_Data_Out=0xA5, Parity_Err=0, Frame_Err=0, RTS=0 until Rx_Ack.
REQ-032 Data 0x01 with parity bit 0 -> Parity_Err=1 (macro defined); Parity_Err=0 (macro undefined); Rx_Data_Out=0x01 both.
REQ-033 Data 0x3C, parity 0, stop bits 1,0 -> Frame_Err=1, Rx_Data_Out=0x3C.
REQ-034 Frame held, start bit driven on Rx before Rx_Ack -> Rx_Valid stays 1, Rx_Data_Out unchanged; Rx_Ack -> IDLE, RTS=1 next cycle.
REQ-035 Rst asserted at cycle 5 of a frame -> next cycle RTS=1, Rx_Valid=0, Rx_Data_Out=0; following 0xA5 frame received correctly.
REQ-036 Back-to-back: Rx_Ack in cycle 12, new start bit cycle 14 -> second frame delivered, Rx_Valid from cycle 26.
